// File: rtl/fifo_stream_reader.sv
// Read-side adapter for a one-cycle-latency block-RAM FIFO: tracks the in-flight read
// and parks returned words in a two-slot skid buffer presented as a valid/ready stream.
module fifo_stream_reader #(
  parameter int WIDTH    = 8,
  parameter int CNT_BITS = 16
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_fifo_empty,
  output logic                o_fifo_read,
  input  logic [WIDTH-1:0]    i_fifo_rdata,
  output logic                o_valid,
  output logic [WIDTH-1:0]    o_data,
  input  logic                i_ready,
  input  logic                i_flush,
  output logic [1:0]          o_level,
  output logic [CNT_BITS-1:0] o_count
);

  logic [WIDTH-1:0]    head;
  logic [WIDTH-1:0]    tail;
  logic [1:0]          level;
  logic                inflight;
  logic [CNT_BITS-1:0] count;

  logic                pop;
  logic [1:0]          occupancy;
  logic [1:0]          kept;
  logic [1:0]          level_next;

  // occupancy = buffered words plus the word still on its way from the FIFO; it never
  // exceeds 2, so a new read is only allowed when a slot is guaranteed for its data.
  always_comb begin
    o_valid     = i_reset & ~i_flush & (level != 2'd0);
    pop         = o_valid & i_ready;
    occupancy   = level + {1'b0, inflight};
    o_fifo_read = i_reset & ~i_flush & ~i_fifo_empty &
                  ((occupancy - {1'b0, pop}) < 2'd2);
    kept        = level - {1'b0, pop};
    level_next  = kept + {1'b0, inflight};
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      level    <= 2'd0;
      inflight <= 1'b0;
      count    <= '0;
    end else if (i_flush) begin
      level    <= 2'd0;
      inflight <= 1'b0;
    end else begin
      inflight <= o_fifo_read;
      level    <= level_next;
      if (pop) begin
        count <= count + 1'b1;
      end
    end
  end

  // Data slots need no reset: level alone decides which slots hold live words.
  always_ff @(posedge i_clock) begin
    if (i_reset && !i_flush) begin
      if (pop) begin
        head <= tail;
      end
      if (inflight) begin
        if (kept == 2'd0) begin
          head <= i_fifo_rdata;
        end else begin
          tail <= i_fifo_rdata;
        end
      end
    end
  end

  assign o_data  = head;
  assign o_level = level;
  assign o_count = count;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: queue-based FIFO model upstream, scoreboard of words read
// but not yet delivered, negedge monitor, and directed plus random scenarios.
module tb_fifo_stream_reader;
  localparam int WIDTH    = 8;
  localparam int CNT_BITS = 16;

  logic                i_clock = 1'b0;
  logic                i_reset;
  logic                i_fifo_empty;
  logic                o_fifo_read;
  logic [WIDTH-1:0]    i_fifo_rdata = '0;
  logic                o_valid;
  logic [WIDTH-1:0]    o_data;
  logic                i_ready;
  logic                i_flush;
  logic [1:0]          o_level;
  logic [CNT_BITS-1:0] o_count;

  logic                wr_en;
  logic [WIDTH-1:0]    wr_data;

  logic [WIDTH-1:0]    fq[$];         // upstream FIFO contents
  logic [WIDTH-1:0]    sb[$];         // words popped from FIFO, not yet delivered
  logic [WIDTH-1:0]    dlog_data[$];  // every delivered word, in order
  int                  dlog_cyc[$];
  int                  fifo_cnt = 0;
  int                  cyc = 0;
  int                  n_reads = 0;
  bit                  rd_last = 1'b0;
  logic [CNT_BITS-1:0] cnt_model = '0;
  int                  errors = 0;
  int                  checks = 0;

  always #5 i_clock = ~i_clock;
  assign i_fifo_empty = (fifo_cnt == 0);

  fifo_stream_reader #(.WIDTH(WIDTH), .CNT_BITS(CNT_BITS)) dut (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_fifo_empty (i_fifo_empty),
    .o_fifo_read  (o_fifo_read),
    .i_fifo_rdata (i_fifo_rdata),
    .o_valid      (o_valid),
    .o_data       (o_data),
    .i_ready      (i_ready),
    .i_flush      (i_flush),
    .o_level      (o_level),
    .o_count      (o_count)
  );

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Upstream FIFO (registered read data, empty from stored count) and scoreboard updates.
  initial begin : fifo_model
    logic [WIDTH-1:0] w;
    bit rd;
    bit tr;
    forever begin
      @(posedge i_clock);
      rd = o_fifo_read;
      tr = o_valid & i_ready;
      if (!i_reset) begin
        fq.delete();
        sb.delete();
        rd_last = 1'b0;
        cnt_model <= '0;
        i_fifo_rdata <= WIDTH'($urandom);
      end else begin
        if (tr) begin
          dlog_data.push_back(o_data);
          dlog_cyc.push_back(cyc);
          if (sb.size() > 0) void'(sb.pop_front());
          cnt_model <= cnt_model + 1'b1;
        end
        if (i_flush) sb.delete();
        rd_last = 1'b0;
        if (rd) n_reads++;
        if (rd && fq.size() > 0) begin
          w = fq.pop_front();
          i_fifo_rdata <= w;
          if (!i_flush) begin
            sb.push_back(w);
            rd_last = 1'b1;
          end
        end else begin
          i_fifo_rdata <= WIDTH'($urandom);
        end
        if (wr_en) fq.push_back(wr_data);
      end
      fifo_cnt <= fq.size();
      cyc++;
    end
  end

  task automatic monitor();
    int lvl;
    bit ev;
    bit er;
    bit tr;
    forever begin
      @(negedge i_clock);
      lvl = sb.size() - int'(rd_last);
      ev  = i_reset && !i_flush && (lvl != 0);
      tr  = ev && i_ready;
      er  = i_reset && !i_flush && (fifo_cnt != 0) && ((sb.size() - int'(tr)) < 2);
      check("mon_valid", o_valid, ev);
      check("mon_read", o_fifo_read, er);
      check("mon_level", o_level, lvl);
      check("mon_count", o_count, cnt_model);
      if (o_valid && sb.size() > 0) check("mon_data", o_data, sb[0]);
    end
  endtask

  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  task automatic reset_dut();
    i_reset = 1'b0;
    wr_en   = 1'b0;
    i_ready = 1'b0;
    i_flush = 1'b0;
    tick();
    tick();
    i_reset = 1'b1;
  endtask

  task automatic write_word(input logic [WIDTH-1:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  initial begin : main
    logic [WIDTH-1:0]    t1w[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [CNT_BITS-1:0] wrap_exp[3] = '{16'hFFFF, 16'h0000, 16'h0001};
    logic [WIDTH-1:0]    in_words[$];
    int base;
    int r0;
    int t_w;
    int sent;
    int mism;

    i_reset = 1'b0;
    i_ready = 1'b0;
    i_flush = 1'b0;
    wr_en   = 1'b0;
    wr_data = '0;
    tick();
    tick();
    @(negedge i_clock);
    check("reset_valid", o_valid, 0);
    check("reset_read", o_fifo_read, 0);
    check("reset_level", o_level, 0);
    check("reset_count", o_count, 0);
    fork
      monitor();
    join_none

    // four words streamed with ready held high
    reset_dut();
    i_ready = 1'b1;
    base = dlog_data.size();
    r0   = n_reads;
    t_w  = cyc;
    for (int k = 0; k < 4; k++) write_word(t1w[k]);
    repeat (8) tick();
    @(negedge i_clock);
    check("t1_deliveries", dlog_data.size() - base, 4);
    check("t1_reads", n_reads - r0, 4);
    check("t1_count", o_count, 4);
    if (dlog_data.size() - base == 4) begin
      for (int k = 0; k < 4; k++) begin
        check("t1_data", dlog_data[base+k], t1w[k]);
        check("t1_cycle", dlog_cyc[base+k] - t_w, 3 + k);
      end
    end

    // back-pressure with 8 preloaded words, then release
    reset_dut();
    r0 = n_reads;
    for (int k = 0; k < 8; k++) write_word(WIDTH'(8'hA0 + k));
    repeat (4) tick();
    @(negedge i_clock);
    check("t2_reads_held", n_reads - r0, 2);
    check("t2_level", o_level, 2);
    check("t2_valid", o_valid, 1);
    check("t2_head", o_data, 8'hA0);
    repeat (3) tick();
    @(negedge i_clock);
    check("t2_head_stable", o_data, 8'hA0);
    check("t2_reads_still", n_reads - r0, 2);
    tick();
    base = dlog_data.size();
    i_ready = 1'b1;
    repeat (12) tick();
    @(negedge i_clock);
    check("t2_deliveries", dlog_data.size() - base, 8);
    if (dlog_data.size() - base == 8) begin
      for (int k = 0; k < 8; k++) begin
        check("t2_data", dlog_data[base+k], 8'hA0 + k);
        if (k > 0) check("t2_no_gap", dlog_cyc[base+k] - dlog_cyc[base+k-1], 1);
      end
    end
    check("t2_reads_total", n_reads - r0, 8);

    // random writes and random ready
    reset_dut();
    base = dlog_data.size();
    sent = 0;
    for (int c = 0; c < 20000; c++) begin
      if (sent == 1000 && dlog_data.size() - base == 1000) break;
      wr_en = (sent < 1000) && ($urandom_range(0, 99) < 60);
      if (wr_en) begin
        wr_data = WIDTH'($urandom);
        in_words.push_back(wr_data);
        sent++;
      end
      i_ready = 1'($urandom_range(0, 1));
      tick();
    end
    wr_en = 1'b0;
    i_ready = 1'b0;
    @(negedge i_clock);
    check("rand_deliveries", dlog_data.size() - base, 1000);
    mism = 0;
    if (dlog_data.size() - base == 1000) begin
      for (int k = 0; k < 1000; k++) if (dlog_data[base+k] != in_words[k]) mism++;
    end
    check("rand_seq_mismatches", mism, 0);

    // flush in steady state (one buffered word, one in flight)
    reset_dut();
    for (int k = 0; k < 8; k++) write_word(WIDTH'(8'h50 + k));
    repeat (4) tick();
    base = dlog_data.size();
    i_ready = 1'b1;
    tick();
    tick();
    i_flush = 1'b1;
    @(negedge i_clock);
    check("t4_pre_level", o_level, 1);
    check("t4_flush_valid", o_valid, 0);
    check("t4_flush_read", o_fifo_read, 0);
    check("t4_pre_delivered", dlog_data.size() - base, 2);
    tick();
    i_flush = 1'b0;
    @(negedge i_clock);
    check("t4_post_valid", o_valid, 0);
    check("t4_post_level", o_level, 0);
    check("t4_post_count", o_count, 2);
    base = dlog_data.size();
    repeat (10) tick();
    @(negedge i_clock);
    check("t4_after_deliveries", dlog_data.size() - base, 4);
    if (dlog_data.size() > base) check("t4_next_word", dlog_data[base], 8'h54);
    check("t4_final_count", o_count, 6);

    // reset while full and with a read in flight
    reset_dut();
    for (int k = 0; k < 4; k++) write_word(WIDTH'(8'h60 + k));
    repeat (4) tick();
    i_ready = 1'b1;
    @(negedge i_clock);
    check("t6_pre_level", o_level, 2);
    check("t6_pre_read", o_fifo_read, 1);
    tick();
    i_reset = 1'b0;
    @(negedge i_clock);
    check("t6_rst_valid", o_valid, 0);
    check("t6_rst_read", o_fifo_read, 0);
    tick();
    i_reset = 1'b1;
    @(negedge i_clock);
    check("t6_valid", o_valid, 0);
    check("t6_level", o_level, 0);
    check("t6_count", o_count, 0);
    base = dlog_data.size();
    write_word(8'hC1);
    write_word(8'hC2);
    repeat (8) tick();
    @(negedge i_clock);
    check("t6_deliveries", dlog_data.size() - base, 2);
    if (dlog_data.size() > base) check("t6_first_word", dlog_data[base], 8'hC1);

    // counter wrap
    reset_dut();
    i_ready = 1'b1;
    for (int k = 0; k < 65534; k++) write_word(WIDTH'(k));
    repeat (6) tick();
    @(negedge i_clock);
    check("wrap_fffe", o_count, 16'hFFFE);
    for (int k = 0; k < 3; k++) begin
      write_word(WIDTH'(8'hE0 + k));
      repeat (6) tick();
      @(negedge i_clock);
      check("wrap_step", o_count, wrap_exp[k]);
    end

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_stream_reader.md
# fifo_stream_reader

Read-side adapter that drains a block-RAM FIFO (one-cycle registered read latency, combinational empty flag) and presents its words as a valid/ready stream. It sits directly downstream of the FIFO's read port and tracks in-flight reads so that no word is lost or duplicated. A two-entry skid buffer sustains one word per cycle while the consumer holds ready high. It also absorbs consumer back-pressure without ever over-reading the FIFO.

## Interface
- WIDTH, 8, data word width; must equal the FIFO's WIDTH.
- CNT_BITS, 16, width of the delivered-word counter.

- i_clock  in  1  clock; all state updates on rising edge.
- i_reset  in  1  synchronous, active-low.
- i_fifo_empty  in  1  FIFO empty flag; reflects reads issued on previous edges.
- o_fifo_read  out  1  FIFO read strobe; one pulse pops one word.
- i_fifo_rdata  in  WIDTH  FIFO read data; valid in the cycle after o_fifo_read.
- o_valid  out  1  stream word available.
- o_data  out  WIDTH  stream word (head of skid buffer).
- i_ready  in  1  consumer accepts o_data this cycle.
- i_flush  in  1  discard buffered and in-flight words.
- o_level  out  2  words held in skid buffer, 0..2.
- o_count  out  CNT_BITS  words delivered since reset; wraps modulo 2^CNT_BITS.

## Operation
- State: two-slot buffer (head, tail), occupancy `level` (0..2), 1-bit `inflight`, counter `count`.
- Invariant: level + inflight <= 2 at every edge.
- pop = o_valid & i_ready; o_valid = (level != 0) & !i_flush; o_data = head slot.
- Read issue (combinational): o_fifo_read = !i_flush & !i_fifo_empty & (level + inflight - pop < 2).
- Next edge:
  - inflight <= o_fifo_read.
  - If inflight was 1, i_fifo_rdata is appended behind the surviving contents.
  - On pop, tail shifts to head.
  - level <= level - pop + inflight.
  - Appended word goes to the head if the buffer is empty after the pop, otherwise to the tail.
- count increments by 1 on each pop; it rolls from 2^CNT_BITS-1 to 0.
- i_fifo_rdata is sampled only in the cycle after a read. Outside those cycles its value is ignored and never relied on to hold.
- Flush (i_flush=1 in a cycle):
  - o_valid and o_fifo_read are forced 0; no transfer and no count change that cycle.
  - Next edge: level <= 0 and inflight <= 0. A word arriving from a read issued the previous cycle is dropped.
  - FIFO contents are untouched; reading resumes the cycle after i_flush deasserts.
- Reset (i_reset=0): level=0, inflight=0, count=0. o_fifo_read=0 and o_valid=0 combinationally while reset is low.
  - Block must be reset together with the upstream FIFO.
  - A read in flight at reset is discarded.

## Timing
- Read-to-valid latency:
  - o_fifo_read in cycle C.
  - Word on i_fifo_rdata in C+1, captured at end of C+1.
  - o_valid=1 in C+2.
- Write to empty FIFO at edge E: empty low in cycle after E, read issued that cycle, o_valid 2 cycles later (3 cycles after the write cycle).
- Throughput: with FIFO non-empty and i_ready held 1, one word per cycle after the 2-cycle fill. Steady state is level=1, inflight=1.
- Back-pressure:
  - i_ready=0 stops reads once level + inflight reaches 2.
  - At most 2 words are outstanding; nothing is overwritten.
- Ready rising with level=2: one pop per cycle. Reads restart in the same cycle as the first pop (level + inflight - pop = 1).
- FIFO going empty mid-stream: reads stop the same cycle; the buffer drains normally; o_valid falls after the last word.
- All outputs except o_fifo_read and o_valid are registered. o_fifo_read depends combinationally on i_fifo_empty, i_ready and i_flush; o_valid depends combinationally on i_flush.

## Test plan
- Reset, then write 4 words 0x11,0x22,0x33,0x44 with i_ready=1 -> exactly 4 o_fifo_read pulses; o_data sequence 0x11..0x44 on consecutive cycles; first o_valid 3 cycles after the first write; o_count=4.
- Preload 8 words, i_ready=0 -> exactly 2 reads issued, level=2, o_data=word0 stable. Raise i_ready -> 8 words on 8 consecutive cycles, in order, no gaps after the first.
- Random i_ready (50%) over 1000 random words with random writes -> output sequence equals input sequence. FIFO never read while empty; level never exceeds 2.
- Pulse i_flush one cycle while level=1 and inflight=1 -> both words dropped, o_valid=0 next cycle. Next delivered word is the FIFO word following the dropped one; o_count is unchanged by the flush.
- Set o_count to 0xFFFE by driving 65534 transfers, then deliver 3 more words -> o_count reads 0xFFFF, 0x0000, 0x0001.
- Assert i_reset=0 with level=2 and a read in flight -> next cycle o_valid=0, o_level=0, o_count=0, no stale word delivered after reset release.
